// File: rtl/z80_mem_slave_if.sv
// Z80 external memory bus: address, memory-cycle strobes and the slave's
// status back to the core. The 8-bit data bus is a shared tristate net and
// is carried as a separate inout port on the slave.
interface z80_mem_slave_if;
    logic [15:0] addr_bus;
    logic        MREQ_L;
    logic        RD_L;
    logic        WR_L;
    logic        RFSH_L;
    logic        WAIT_L;
    logic        bus_err;
    logic        drive_en;  // slave is currently driving data_bus

    modport master (
        output addr_bus, MREQ_L, RD_L, WR_L, RFSH_L,
        input  WAIT_L, bus_err, drive_en
    );

    modport slave (
        input  addr_bus, MREQ_L, RD_L, WR_L, RFSH_L,
        output WAIT_L, bus_err, drive_en
    );
endinterface

// File: rtl/z80_mem_slave.sv
// Byte-wide memory slave on the Z80 bus with programmable wait states.
// Decodes MREQ_L/RD_L/WR_L memory cycles (refresh and IO are ignored),
// stretches the cycle through WAIT_L, drives data_bus on reads and captures
// it on writes. Both-strobes-low requests raise a sticky bus_err.
// Optional feature: define Z80_MEM_WRPROT_EN to discard writes whose latched
// address is <= ROM_TOP; without it the whole array is writable.
module z80_mem_slave #(
    parameter int          ADDR_BITS   = 16,
    parameter int          WAIT_STATES = 0,
    parameter int unsigned ROM_TOP     = 'h0FFF
) (
    input  logic              clk,
    input  logic              rst,
    z80_mem_slave_if.slave    bus,
    inout  wire  [7:0]        data_bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   rd_op_q, rd_op_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   wait_l_q, wait_l_d;
    logic                   drive_en_q, drive_en_d;
    logic                   bus_err_q, bus_err_d;
    logic [7:0]             data_out_q, data_out_d;

    logic [7:0]             mem [0:(1<<ADDR_BITS)-1];
    logic                   mem_we;
    logic                   req, both_low, strobe_on, wr_blk;
    logic [31:0]            addr_ext;

    assign bus.WAIT_L   = wait_l_q;
    assign bus.bus_err  = bus_err_q;
    assign bus.drive_en = drive_en_q;
    assign data_bus     = drive_en_q ? data_out_q : 8'hzz;

    // Next-state and registered-output decode for the bus cycle FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_op_d    = rd_op_q;
        cnt_d      = cnt_q;
        wait_l_d   = wait_l_q;
        drive_en_d = drive_en_q;
        bus_err_d  = bus_err_q;
        data_out_d = data_out_q;
        mem_we     = 1'b0;

        req       = !bus.MREQ_L && bus.RFSH_L && (bus.RD_L != bus.WR_L);
        both_low  = !bus.MREQ_L && !bus.RD_L && !bus.WR_L;
        // The strobe that opened this cycle is still asserted.
        strobe_on = !bus.MREQ_L && (rd_op_q ? !bus.RD_L : !bus.WR_L);

        addr_ext = 32'(addr_q);
`ifdef Z80_MEM_WRPROT_EN
        wr_blk = (addr_ext <= ROM_TOP);
`else
        // Region compare is forced off: every location is writable.
        wr_blk = 1'b0 && (addr_ext <= ROM_TOP);
`endif

        case (state_q)
            S_IDLE: begin
                if (both_low) begin
                    bus_err_d = 1'b1;
                end else if (req) begin
                    addr_d  = bus.addr_bus[ADDR_BITS-1:0];
                    rd_op_d = !bus.RD_L;
                    if (WAIT_STATES > 0) begin
                        state_d  = S_WAIT;
                        cnt_d    = 4'(WAIT_STATES - 1);
                        wait_l_d = 1'b0;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (!strobe_on) begin
                    // Core abandoned the cycle: no write, no drive.
                    state_d  = S_IDLE;
                    wait_l_d = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d  = S_ACCESS;
                    wait_l_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                // RAM read is registered here; the bus enable follows one
                // edge later so data_out is already stable when driven.
                if (rd_op_q) data_out_d = mem[addr_q];
                else         mem_we     = !wr_blk;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!strobe_on) begin
                    drive_en_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    drive_en_d = rd_op_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and output registers; reset overrides any cycle in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rd_op_q    <= 1'b0;
            cnt_q      <= 4'd0;
            wait_l_q   <= 1'b1;
            drive_en_q <= 1'b0;
            bus_err_q  <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_op_q    <= rd_op_d;
            cnt_q      <= cnt_d;
            wait_l_q   <= wait_l_d;
            drive_en_q <= drive_en_d;
            bus_err_q  <= bus_err_d;
            data_out_q <= data_out_d;
        end
    end

    // Single write commit per cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[addr_q] <= data_bus;
    end

endmodule
